// File: rtl/hack_pkg.sv
// Shared constants for the multi-cycle Hack CPU: FSM encodings and instruction field layout.
package hack_pkg;

    localparam logic [2:0] StStart  = 3'd0;
    localparam logic [2:0] StFetch  = 3'd1;
    localparam logic [2:0] StMread  = 3'd2;
    localparam logic [2:0] StExec   = 3'd3;
    localparam logic [2:0] StMwrite = 3'd4;

    localparam int unsigned IdxCFlag = 15;
    localparam int unsigned IdxABit  = 12;
    localparam int unsigned CompMsb  = 11;
    localparam int unsigned CompLsb  = 6;
    localparam int unsigned DestMsb  = 5;
    localparam int unsigned DestLsb  = 3;
    localparam int unsigned JumpMsb  = 2;
    localparam int unsigned JumpLsb  = 0;

    // Bit positions inside the 3-bit dest and jump fields.
    localparam int unsigned DestA = 2;
    localparam int unsigned DestD = 1;
    localparam int unsigned DestM = 0;
    localparam int unsigned JmpLt = 2;
    localparam int unsigned JmpEq = 1;
    localparam int unsigned JmpGt = 0;

    function automatic logic needs_mread(input logic [15:0] instr);
        return instr[IdxCFlag] & instr[IdxABit];
    endfunction

endpackage

// File: rtl/hack_alu.sv
// Hack ALU: control = {zx, nx, zy, ny, f, no}; zr/ng flag a zero/negative result.
module hack_alu #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    input  logic [5:0]       control_i,
    output logic [WIDTH-1:0] out_o,
    output logic             zr_o,
    output logic             ng_o
);

    logic [WIDTH-1:0] x_m;
    logic [WIDTH-1:0] y_m;
    logic [WIDTH-1:0] res;

    always_comb begin
        x_m = control_i[5] ? '0 : x_i;
        if (control_i[4]) x_m = ~x_m;
        y_m = control_i[3] ? '0 : y_i;
        if (control_i[2]) y_m = ~y_m;
        res = control_i[1] ? (x_m + y_m) : (x_m & y_m);
        if (control_i[0]) res = ~res;
    end

    assign out_o = res;
    assign zr_o  = (res == '0);
    assign ng_o  = res[WIDTH-1];

endmodule

// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack CPU: START/FETCH/MREAD/EXEC/MWRITE sequencer around hack_alu,
// with request/grant handshakes to instruction and data memory.
module hack_cpu_mc
    import hack_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AW    = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req_o,
    output logic [AW-1:0]    imem_addr_o,
    input  logic             imem_gnt_i,
    input  logic [WIDTH-1:0] imem_rdata_i,
    output logic             dmem_req_o,
    output logic             dmem_we_o,
    output logic [AW-1:0]    dmem_addr_o,
    output logic [WIDTH-1:0] dmem_wdata_o,
    input  logic             dmem_gnt_i,
    input  logic [WIDTH-1:0] dmem_rdata_i,
    output logic [AW-1:0]    pc_o
);

    logic [2:0]       state_q, state_d;
    logic [AW-1:0]    pc_q, pc_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] ir_q, ir_d;
    logic [WIDTH-1:0] mreg_q, mreg_d;
    logic [AW-1:0]    waddr_q, waddr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;

    logic [WIDTH-1:0] alu_y;
    logic [WIDTH-1:0] alu_out;
    logic             alu_zr;
    logic             alu_ng;
    logic [2:0]       dest;
    logic [2:0]       jump;
    logic             taken;
    logic [AW-1:0]    pc_inc;

    // ir[14:13] and the top bit of A never affect behaviour.
    logic unused_bits;
    assign unused_bits = ^{ir_q[14:13], a_q[WIDTH-1:AW]};

    assign dest   = ir_q[DestMsb:DestLsb];
    assign jump   = ir_q[JumpMsb:JumpLsb];
    assign alu_y  = ir_q[IdxABit] ? mreg_q : a_q;
    assign pc_inc = pc_q + AW'(1);
    assign taken  = (jump[JmpLt] & alu_ng) | (jump[JmpEq] & alu_zr)
                  | (jump[JmpGt] & ~alu_zr & ~alu_ng);

    hack_alu #(
        .WIDTH(WIDTH)
    ) u_alu (
        .x_i      (d_q),
        .y_i      (alu_y),
        .control_i(ir_q[CompMsb:CompLsb]),
        .out_o    (alu_out),
        .zr_o     (alu_zr),
        .ng_o     (alu_ng)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        a_d     = a_q;
        d_d     = d_q;
        ir_d    = ir_q;
        mreg_d  = mreg_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (state_q)
            StStart: state_d = StFetch;
            StFetch: begin
                if (imem_gnt_i) begin
                    ir_d    = imem_rdata_i;
                    state_d = needs_mread(imem_rdata_i[15:0]) ? StMread : StExec;
                end
            end
            StMread: begin
                if (dmem_gnt_i) begin
                    mreg_d  = dmem_rdata_i;
                    state_d = StExec;
                end
            end
            StExec: begin
                if (!ir_q[IdxCFlag]) begin
                    a_d     = ir_q;
                    pc_d    = pc_inc;
                    state_d = StFetch;
                end else begin
                    if (dest[DestA]) a_d = alu_out;
                    if (dest[DestD]) d_d = alu_out;
                    // Write-back and jump target both use A as it was before this update.
                    waddr_d = a_q[AW-1:0];
                    wdata_d = alu_out;
                    pc_d    = taken ? a_q[AW-1:0] : pc_inc;
                    state_d = dest[DestM] ? StMwrite : StFetch;
                end
            end
            StMwrite: begin
                if (dmem_gnt_i) state_d = StFetch;
            end
            default: state_d = StStart;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StStart;
            pc_q    <= '0;
            a_q     <= '0;
            d_q     <= '0;
            ir_q    <= '0;
            mreg_q  <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            a_q     <= a_d;
            d_q     <= d_d;
            ir_q    <= ir_d;
            mreg_q  <= mreg_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign imem_req_o   = (state_q == StFetch);
    assign imem_addr_o  = pc_q;
    assign dmem_req_o   = (state_q == StMread) || (state_q == StMwrite);
    assign dmem_we_o    = (state_q == StMwrite);
    assign dmem_addr_o  = dmem_we_o ? waddr_q : a_q[AW-1:0];
    assign dmem_wdata_o = wdata_q;
    assign pc_o         = pc_q;

endmodule
